// File: rtl/ifetch.sv
// Instruction fetch front end: credit-limited requests to instruction memory,
// in-order response buffer to decode, and flush with stale-response dropping.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_req_val,
  input  logic        i_req_rdy,
  output logic [31:0] o_req_addr,
  input  logic        i_rsp_val,
  input  logic [31:0] i_rsp_data,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc,
  output logic        o_ir_val,
  input  logic        i_ir_rdy,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = 16;

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_drop;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_buf_ir [DEPTH];
  logic [31:0]   r_buf_pc [DEPTH];

  logic [31:0]   w_flush_pc;
  logic [CW:0]   w_credits_used;
  logic          w_req_fire;
  logic          w_dropping;
  logic          w_push;
  logic          w_pop;

  assign w_flush_pc     = i_flush_pc & 32'hFFFF_FFFC;
  assign w_credits_used = {1'b0, r_outstanding} + {1'b0, r_count};

  // Gated by reset so the request line is quiet while reset is held.
  assign o_req_val  = i_rst_n & ~i_flush & (w_credits_used < DEPTH[CW:0]);
  assign o_req_addr = r_pc;
  assign w_req_fire = o_req_val & i_req_rdy;

  assign w_dropping = (r_drop != '0);
  assign w_push     = i_rsp_val & ~w_dropping & ~i_flush;

  assign o_ir_val = (r_count != '0) & ~i_flush;
  assign w_pop    = o_ir_val & i_ir_rdy;
  assign o_ir     = r_buf_ir[r_rptr];
  assign o_pc     = r_buf_pc[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
    end else if (i_flush) begin
      r_pc     <= w_flush_pc;
      r_rsp_pc <= w_flush_pc;
    end else begin
      if (w_req_fire) r_pc     <= r_pc + 32'd4;
      if (w_push)     r_rsp_pc <= r_rsp_pc + 32'd4;
    end
  end

  // Outstanding only tracks requests whose responses will be kept; on flush
  // those move into the drop counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (i_flush) begin
      r_outstanding <= '0;
      r_drop        <= r_drop + DW'(r_outstanding) - DW'(i_rsp_val);
    end else begin
      case ({w_req_fire, w_push})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (i_rsp_val && w_dropping) r_drop <= r_drop - DW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (i_flush) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf_ir[r_wptr] <= i_rsp_data;
      r_buf_pc[r_wptr] <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed flush vectors, streaming/backpressure/reset
// sequences, and a randomized memory checked against an epoch-based model.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_req_val;
  logic        i_req_rdy = 1'b0;
  logic [31:0] o_req_addr;
  logic        i_rsp_val = 1'b0;
  logic [31:0] i_rsp_data = '0;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        o_ir_val;
  logic        i_ir_rdy = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_pc = '0;

  always #5 i_clk = ~i_clk;

  ifetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_req_val(o_req_val), .i_req_rdy(i_req_rdy), .o_req_addr(o_req_addr),
    .i_rsp_val(i_rsp_val), .i_rsp_data(i_rsp_data),
    .o_ir(o_ir), .o_pc(o_pc), .o_ir_val(o_ir_val), .i_ir_rdy(i_ir_rdy),
    .i_flush(i_flush), .i_flush_pc(i_flush_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned ep;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc1;
    bit          dbl;
    logic [31:0] pc2;
    logic [31:0] e_req;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
  } fvec_t;

  mreq_t       memq[$];
  logic [31:0] popped[$];
  logic [31:0] req_addrs[$];
  int          pop_cyc[$];
  int          acc_cyc[$];
  fvec_t       tv[5];

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int unsigned epoch = 0;
  int unsigned rsp_ep = 0;
  int          acc, kept, pops, n_dut_acc;
  logic [31:0] exp_req_pc, exp_pc;
  int          rdy_pct, ir_pct, lat_min, lat_max;
  bit          flush_arm = 1'b0;
  logic [31:0] flush_tgt;
  logic        s_ir_val;
  logic [31:0] s_pc, s_ir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    popped.delete();
    req_addrs.delete();
    pop_cyc.delete();
    acc_cyc.delete();
    epoch++;
    acc = 0; kept = 0; pops = 0; n_dut_acc = 0;
    exp_req_pc = RST_PC;
    exp_pc = RST_PC;
    flush_arm = 1'b0;
  endtask

  // Called between clock edges; asserts reset asynchronously and releases it
  // just after a rising edge.
  task automatic do_reset();
    #1;
    i_rst_n = 1'b0;
    i_req_rdy = 1'b0; i_rsp_val = 1'b0; i_ir_rdy = 1'b0;
    i_flush = 1'b0; i_flush_pc = '0; i_rsp_data = '0;
    #1;
    chk("rst_req_val", 32'(o_req_val), 0);
    chk("rst_ir_val", 32'(o_ir_val), 0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    #1;
    chk("post_rst_req_val", 32'(o_req_val), 1);
    chk("post_rst_req_addr", o_req_addr, RST_PC);
  endtask

  task automatic step();
    mreq_t r;
    bit    exp_rv, exp_iv;
    @(posedge i_clk);
    cyc++;
    #1;
    i_req_rdy  = ($urandom_range(0, 99) < rdy_pct);
    i_ir_rdy   = ($urandom_range(0, 99) < ir_pct);
    i_flush    = flush_arm;
    i_flush_pc = flush_arm ? flush_tgt : $urandom;
    flush_arm  = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      i_rsp_val  = 1'b1;
      i_rsp_data = mem_word(r.addr);
      rsp_ep     = r.ep;
    end else begin
      i_rsp_val  = 1'b0;
      i_rsp_data = $urandom;
    end
    @(negedge i_clk);
    s_ir_val = o_ir_val;
    s_pc     = o_pc;
    s_ir     = o_ir;
    exp_rv = !i_flush && (acc - pops < DEPTH);
    exp_iv = !i_flush && (kept > pops);
    chk("req_val", 32'(o_req_val), 32'(exp_rv));
    chk("ir_val", 32'(o_ir_val), 32'(exp_iv));
    if (exp_rv) chk("req_addr", o_req_addr, exp_req_pc);
    if (exp_iv) begin
      chk("o_pc", o_pc, exp_pc);
      chk("o_ir", o_ir, mem_word(exp_pc));
    end
    if (o_req_val && i_req_rdy) begin
      n_dut_acc++;
      acc_cyc.push_back(cyc);
      req_addrs.push_back(o_req_addr);
    end
    if (o_ir_val && i_ir_rdy) begin
      popped.push_back(o_pc);
      pop_cyc.push_back(cyc);
    end
    if (i_flush) begin
      epoch++;
      acc = 0; kept = 0; pops = 0;
      exp_req_pc = i_flush_pc & 32'hFFFF_FFFC;
      exp_pc     = i_flush_pc & 32'hFFFF_FFFC;
      popped.delete(); req_addrs.delete(); pop_cyc.delete(); acc_cyc.delete();
    end else begin
      if (exp_rv && i_req_rdy) begin
        memq.push_back('{addr: exp_req_pc, ep: epoch,
                         due: cyc + int'($urandom_range(lat_min, lat_max))});
        acc++;
        exp_req_pc += 32'd4;
      end
      if (i_rsp_val && rsp_ep == epoch) kept++;
      if (exp_iv && i_ir_rdy) begin
        pops++;
        exp_pc += 32'd4;
      end
    end
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
    tv[0] = '{32'h0000_0103, 1'b0, 32'h0,         32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    tv[1] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    tv[2] = '{32'h1234_5677, 1'b0, 32'h0,         32'h1234_5674, 32'h1234_5674, 32'h1234_5678};
    tv[3] = '{32'h0000_0040, 1'b1, 32'h0000_2002, 32'h0000_2000, 32'h0000_2000, 32'h0000_2004};
    tv[4] = '{32'h0000_0001, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0004};

    // Flush with two requests in flight, target table.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      lat_min = 3; lat_max = 3; rdy_pct = 100; ir_pct = 100;
      for (int k = 0; k < 20 && acc < 2; k++) step();
      chk("tv_setup_reqs", n_dut_acc, 2);
      flush_arm = 1'b1; flush_tgt = tv[i].pc1;
      step();
      if (tv[i].dbl) begin
        flush_arm = 1'b1; flush_tgt = tv[i].pc2;
        step();
      end
      for (int k = 0; k < 40 && popped.size() < 2; k++) step();
      if (popped.size() < 2 || req_addrs.size() < 1) begin
        chk("tv_timeout", popped.size(), 2);
      end else begin
        chk("tv_first_req", req_addrs[0], tv[i].e_req);
        chk("tv_pc0", popped[0], tv[i].e_pc0);
        chk("tv_pc1", popped[1], tv[i].e_pc1);
      end
    end

    // Streaming at latency 1 with everything ready.
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; ir_pct = 100;
    repeat (16) step();
    if (popped.size() < 12) begin
      chk("stream_count", popped.size(), 12);
    end else begin
      for (int i = 0; i < 3; i++) chk("stream_pc", popped[i], RST_PC + 32'(4 * i));
      chk("stream_latency", pop_cyc[0] - acc_cyc[0], 2);
      for (int i = 0; i < 10; i++) chk("stream_gap", pop_cyc[i+1] - pop_cyc[i], 1);
    end

    // Backpressure from decode.
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; ir_pct = 0;
    repeat (10) step();
    chk("bp_reqs", n_dut_acc, DEPTH);
    chk("bp_ir_val", 32'(s_ir_val), 1);
    chk("bp_pc", s_pc, RST_PC);
    chk("bp_ir", s_ir, mem_word(RST_PC));
    ir_pct = 100;
    repeat (12) step();
    if (popped.size() < DEPTH + 2) begin
      chk("bp_drain_count", popped.size(), DEPTH + 2);
    end else begin
      for (int i = 0; i < DEPTH + 2; i++) chk("bp_order", popped[i], RST_PC + 32'(4 * i));
    end

    // Flush coinciding with a response and a pop attempt.
    do_reset();
    lat_min = 2; lat_max = 2; rdy_pct = 100; ir_pct = 0;
    for (int k = 0; k < 20 && !(kept > pops && memq.size() > 0 && memq[0].due == cyc + 1); k++)
      step();
    flush_arm = 1'b1; flush_tgt = 32'h0000_4000; ir_pct = 100;
    step();
    chk("fr_ir_val_F", 32'(s_ir_val), 0);
    step();
    chk("fr_empty_F1", 32'(s_ir_val), 0);
    repeat (20) step();
    if (popped.size() < 1) chk("fr_timeout", popped.size(), 1);
    else chk("fr_first_pc", popped[0], 32'h0000_4000);

    // Randomized traffic with random flushes.
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      rdy_pct = $urandom_range(30, 100);
      ir_pct  = $urandom_range(20, 100);
      lat_min = $urandom_range(1, 3);
      lat_max = lat_min + $urandom_range(0, 4);
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 99) < 3) begin
          flush_arm = 1'b1;
          flush_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
        end
        step();
      end
    end

    // Reset in the middle of a stream.
    lat_min = 1; lat_max = 1; rdy_pct = 100; ir_pct = 100;
    repeat (8) step();
    chk("mid_ir_val_before", 32'(s_ir_val), 1);
    do_reset();
    repeat (10) step();
    if (popped.size() < 1) chk("mid_timeout", popped.size(), 1);
    else chk("mid_first_pc", popped[0], RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, which is the instruction buffer entries and also the in-flight credit limit; legal values are 2 and 4.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port o_req_val, output, 1 bit: instruction memory request valid.
REQ-006 SHALL have port i_req_rdy, input, 1 bit: memory accepts the request.
REQ-007 SHALL have port o_req_addr, output, 32 bits: fetch address, always word-aligned.
REQ-008 SHALL have port i_rsp_val, input, 1 bit: response valid; responses are in order, with latency of 1 or more cycles and no backpressure.
REQ-009 SHALL have port i_rsp_data, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port o_ir, output, 32 bits: instruction to decode.
REQ-011 SHALL have port o_pc, output, 32 bits: address of o_ir.
REQ-012 SHALL have port o_ir_val, output, 1 bit: o_ir/o_pc valid.
REQ-013 SHALL have port i_ir_rdy, input, 1 bit: decode accepts o_ir.
REQ-014 SHALL have port i_flush, input, 1 bit: redirect from branch/jump unit.
REQ-015 SHALL have port i_flush_pc, input, 32 bits: redirect target; bits [1:0] ignored and treated as 0.

Function
REQ-016 SHALL hold fetch PC register pc; o_req_addr = pc; a request is accepted when o_req_val & i_req_rdy; on acceptance pc <= pc + 4, with 32-bit wrap (32'hFFFF_FFFC -> 32'h0).
REQ-017 SHALL drive o_req_val = ~i_flush & (outstanding + count < DEPTH), where outstanding = accepted requests not yet responded and count = buffer occupancy; the buffer therefore never overflows.
REQ-018 SHALL update outstanding by +1 on request accept and -1 on i_rsp_val; simultaneous accept and response leave it unchanged.
REQ-019 SHALL hold drop counter drop; a response arriving while drop != 0 is discarded and decrements drop, without touching the buffer or rsp_pc.
REQ-020 SHALL hold rsp_pc, the address of the next kept response; each kept response pushes {rsp_pc, i_rsp_data} into the buffer and rsp_pc <= rsp_pc + 4.
REQ-021 SHALL implement the buffer as a DEPTH-entry circular FIFO with wrapping pointers; push and pop in the same cycle are legal at any occupancy, including full (count unchanged) and empty-with-push (no bypass).
REQ-022 SHALL drive o_ir/o_pc from the FIFO head and o_ir_val = (count != 0) & ~i_flush; pop occurs when o_ir_val & i_ir_rdy.
REQ-023 SHALL have a latency of request accepted in cycle N, response in cycle N+k, o_ir_val high in cycle N+k+1.
REQ-024 SHALL, on i_flush in cycle F, set pc <= i_flush_pc and rsp_pc <= i_flush_pc, empty the FIFO, issue no request, and perform no pop.
REQ-025 SHALL, on i_flush in cycle F, set drop <= outstanding + drop - (i_rsp_val ? 1 : 0); a response arriving in cycle F is discarded.
REQ-026 SHALL honour every i_flush; back-to-back flushes are each applied, and the last one wins pc.
REQ-027 SHALL, from F+1, resume fetching at i_flush_pc; the first post-flush instruction is presented only after all dropped responses have drained.
REQ-028 SHALL keep the FIFO and o_ir_val unchanged while i_ir_rdy = 0, and requests stop once credits are exhausted.

Reset
REQ-029 SHALL, while i_rst_n = 0, asynchronously set pc = rsp_pc = RESET_PC, outstanding = drop = count = 0, FIFO pointers = 0, o_req_val = 0, and o_ir_val = 0.
REQ-030 SHALL discard in-flight transactions on reset mid-operation; the environment guarantees no responses for pre-reset requests after reset deasserts.
REQ-031 SHALL assert o_req_val with o_req_addr = RESET_PC in the first cycle after deassertion, provided i_flush = 0.

Verification
REQ-032 SHALL verify streaming: with rdy always 1 and latency 1, after reset o_pc sequence is 8000_0000, 8000_0004, 8000_0008, each paired with its data, with no gaps after fill.
REQ-033 SHALL verify backpressure: with i_ir_rdy = 0 for 10 cycles, exactly DEPTH requests are issued, o_ir_val holds the 8000_0000 word, and there is no overflow or loss.
REQ-034 SHALL verify flush with 2 outstanding: with i_flush_pc = 32'h0000_0103, the next 2 responses are dropped, the next request address is 32'h0000_0100, and the first o_pc is 0000_0100.
REQ-035 SHALL verify flush coinciding with a response and a pop: that response is dropped, o_ir_val = 0 in cycle F, and the FIFO is empty in F+1.
REQ-036 SHALL verify wrap: with i_flush_pc = 32'hFFFF_FFFC, o_pc is FFFF_FFFC then 0000_0000.
REQ-037 SHALL verify reset asserted mid-stream: outputs clear immediately, and after release o_req_addr = 8000_0000.
